ec_point_add_dbl: RTL
=====================

Name: ec_point_add_dbl

Overview:
Unified affine elliptic-curve point adder/doubler over GF(p), for curves y^2 = x^3 + a*x + b. It is the parametrised successor to the fixed add-only point adder, and is the arithmetic core for the scalar-multiplication controller. It adds these over the add-only block:
- start/busy/done handshake
- point-at-infinity operands
- automatic doubling when P == Q
- runtime curve parameter a

Parameters:
N, 10, coordinate and modulus width in bits.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  request; sampled only in IDLE
p  in  N  odd prime modulus, 5 <= p < 2^N; held stable while busy
a  in  N  curve coefficient a, < p; held stable while busy
x1, y1  in  N  operand P coordinates
inf1  in  1  P is point at infinity; x1/y1 ignored
x2, y2  in  N  operand Q coordinates
inf2  in  1  Q is point at infinity; x2/y2 ignored
busy  out  1  high from the cycle after start is accepted until done
done  out  1  single-cycle completion pulse
x3, y3  out  N  result coordinates (0 when inf3 = 1)
inf3  out  1  result is point at infinity
err  out  1  operand range error (see Optional Feature)

Behaviour:
- Reset (reset = 0 at a clk edge): FSM goes to IDLE; busy, done, x3, y3, inf3, err all 0. Reset mid-operation aborts with no done pulse.
- Accept: start = 1 in IDLE at edge k latches p, a, all operands and flags. busy = 1 from cycle k+1.
- start while busy is ignored. Outputs hold their last result until the next accept; they are not cleared on accept.
- States: IDLE -> CLASSIFY -> {FINISH | NUM -> INV -> LAM -> X3 -> Y3 -> FINISH} -> IDLE.
- CLASSIFY (one cycle), priority order:
  1. inf1: result = (x2, y2, inf2).
  2. inf2: result = (x1, y1, 0).
  3. x1 == x2 and (y1 != y2 or y1 == 0): result = infinity.
  4. x1 == x2 and y1 == y2: doubling; num = 3*x1^2 + a, den = 2*y1.
  5. Otherwise: addition; num = y2 - y1, den = x2 - x1.
- Trivial cases (1-3): FINISH directly. done = 1 and results valid in cycle k+2; busy drops in the same cycle done rises.
- Arithmetic:
  - All values mod p, kept in [0, p-1].
  - Add/sub use N+1-bit intermediates followed by one conditional +/- p.
  - Multiply: interleaved shift-add modular multiplier, MSB first, N cycles per product.
  - Inverse: binary extended Euclid (u, v, x1', x2'), at most 2N iterations. den is never 0 when INV is entered.
- Full path:
  - lambda = num * den^-1
  - x3 = lambda^2 - x1 - x2
  - y3 = lambda*(x1 - x3) - y1
  - inf3 = 0
- Latency: done at most 8N+16 cycles after the accept edge. Latency may be data-dependent (inversion) but is bounded by that value.
- done is high for exactly one cycle. x3/y3/inf3/err update in the same cycle done rises and are stable through the following IDLE.
- No on-curve check; operands not on the curve give arithmetically defined but meaningless results.

Optional Feature:
Macro ECC_RANGE_CHECK_EN.
- Defined:
  - In CLASSIFY, any non-infinity operand with a coordinate >= p takes FINISH with err = 1, inf3 = 0, x3 = y3 = 0.
  - done timing is the same as for trivial cases.
  - err clears on the next accept.
- Undefined:
  - err is tied to 0.
  - Out-of-range inputs give undefined results, but the FSM still completes within the latency bound.

Test Plan:
1. N=10, p=17, a=2; P=(6,3), Q=(5,1) -> done within 96 cycles; x3=10, y3=6, inf3=0, busy drops with done.
2. p=17, a=2; P=Q=(5,1) (doubling) -> x3=6, y3=3, inf3=0.
3. p=17; P=(5,1), Q=(5,16) -> inf3=1, x3=y3=0, done exactly 2 cycles after accept. Same result for P=Q=(3,0).
4. inf1=1, Q=(5,1) -> (5,1, inf3=0) at k+2. inf2=1, P=(6,3) -> (6,3). inf1=inf2=1 -> inf3=1.
5. Start case 1, pulse start again mid-op (ignored), then drive reset=0 for one cycle at cycle 20 -> busy=0, done never pulses, outputs 0. A fresh start then yields (10,6).
6. With ECC_RANGE_CHECK_EN: P=(17,3), Q=(5,1), p=17 -> err=1, x3=y3=0 at k+2. A following valid case-1 accept clears err.

Source files
------------

// File: rtl/ec_point_add_dbl.sv
// Unified affine elliptic-curve point adder/doubler over GF(p) for
// y^2 = x^3 + a*x + b, with start/busy/done handshake, point-at-infinity
// operands, automatic doubling when P == Q and a runtime coefficient a.
// One shared MSB-first shift-add modular multiplier (N cycles per product)
// and a binary extended-Euclid inverter (at most 2N steps).
// Optional build macro: ECC_RANGE_CHECK_EN (coordinate >= p raises err).
module ec_point_add_dbl #(
   parameter int N = 10
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic [N-1:0] i_p,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_x1,
   input  logic [N-1:0] i_y1,
   input  logic         i_inf1,
   input  logic [N-1:0] i_x2,
   input  logic [N-1:0] i_y2,
   input  logic         i_inf2,
   output logic         o_busy,
   output logic         o_done,
   output logic [N-1:0] o_x3,
   output logic [N-1:0] o_y3,
   output logic         o_inf3,
   output logic         o_err
);

   localparam int CW = $clog2(2 * N + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLASSIFY, S_NUM, S_INV, S_LAM, S_X3, S_Y3, S_FINISH
   } state_t;

   state_t r_state, w_state_next;

   // latched operands
   logic [N-1:0] r_p, r_a, r_x1, r_y1, r_x2, r_y2;
   logic         r_inf1, r_inf2, r_dbl;
   // slope numerator/denominator, slope, temporary x3
   logic [N-1:0] r_num, r_den, r_lam, r_x3t;
   // inverter state: u, v and their cofactors
   logic [N-1:0] r_u, r_v, r_g1, r_g2;
   // multiplier state: scanned operand, addend, accumulator
   logic [N-1:0] r_ma, r_mb, r_acc;
   logic [CW-1:0] r_cnt;
   // result registers
   logic         r_busy, r_done, r_inf3;
   logic [N-1:0] r_x3, r_y3;

   function automatic logic [N-1:0] mod_add(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [N-1:0] m);
      logic [N:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m})
         s = s - {1'b0, m};
      return s[N-1:0];
   endfunction

   function automatic logic [N-1:0] mod_sub(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [N-1:0] m);
      logic [N:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (a < b)
         d = d + {1'b0, m};
      return d[N-1:0];
   endfunction

   // x/2 mod m for odd m: add m first when x is odd so the shift is exact
   function automatic logic [N-1:0] mod_half(input logic [N-1:0] x,
                                             input logic [N-1:0] m);
      logic [N:0] s;
      s = {1'b0, x} + (x[0] ? {1'b0, m} : {(N+1){1'b0}});
      return s[N:1];
   endfunction

   logic [N-1:0] w_acc_step, w_num, w_x3, w_inv, w_g_diff12, w_g_diff21;
   logic         w_mul_last, w_inv_done, w_cancel, w_dbl, w_rng, w_trivial;

   // one multiplier step: acc = 2*acc + (msb ? b : 0), reduced mod p
   assign w_acc_step = mod_add(mod_add(r_acc, r_acc, r_p),
                               r_ma[N-1] ? r_mb : {N{1'b0}}, r_p);
   assign w_mul_last = (r_cnt == CW'(N - 1));

   // doubling numerator 3*x1^2 + a from the finishing square
   assign w_num = mod_add(mod_add(mod_add(w_acc_step, w_acc_step, r_p),
                                  w_acc_step, r_p), r_a, r_p);
   // x3 = lambda^2 - x1 - x2 from the finishing square
   assign w_x3  = mod_sub(mod_sub(w_acc_step, r_x1, r_p), r_x2, r_p);

   // the step counter also bounds the inverter if den happens to be 0 mod p
   assign w_inv_done = (r_u == N'(1)) || (r_v == N'(1)) || (r_cnt == CW'(2 * N));
   assign w_inv      = (r_u == N'(1)) ? r_g1 : r_g2;
   assign w_g_diff12 = mod_sub(r_g1, r_g2, r_p);
   assign w_g_diff21 = mod_sub(r_g2, r_g1, r_p);

   assign w_cancel  = (r_x1 == r_x2) && ((r_y1 != r_y2) || (r_y1 == '0));
   assign w_dbl     = (r_x1 == r_x2) && (r_y1 == r_y2);
`ifdef ECC_RANGE_CHECK_EN
   assign w_rng = (!r_inf1 && ((r_x1 >= r_p) || (r_y1 >= r_p))) ||
                  (!r_inf2 && ((r_x2 >= r_p) || (r_y2 >= r_p)));
`else
   assign w_rng = 1'b0;
`endif
   assign w_trivial = w_rng || r_inf1 || r_inf2 || w_cancel;

   // state register
   always_ff @(posedge i_clk) begin
      if (!i_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:     if (i_start) w_state_next = S_CLASSIFY;
         S_CLASSIFY: w_state_next = w_trivial ? S_FINISH : S_NUM;
         S_NUM:      if (!r_dbl || w_mul_last) w_state_next = S_INV;
         S_INV:      if (w_inv_done) w_state_next = S_LAM;
         S_LAM:      if (w_mul_last) w_state_next = S_X3;
         S_X3:       if (w_mul_last) w_state_next = S_Y3;
         S_Y3:       if (w_mul_last) w_state_next = S_FINISH;
         S_FINISH:   w_state_next = S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
   end

`ifdef ECC_RANGE_CHECK_EN
   logic r_err;
   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif

   // datapath, handshake and result registers
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_x3   <= '0;
         r_y3   <= '0;
         r_inf3 <= 1'b0;
`ifdef ECC_RANGE_CHECK_EN
         r_err  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_p    <= i_p;
                  r_a    <= i_a;
                  r_x1   <= i_x1;
                  r_y1   <= i_y1;
                  r_inf1 <= i_inf1;
                  r_x2   <= i_x2;
                  r_y2   <= i_y2;
                  r_inf2 <= i_inf2;
                  r_busy <= 1'b1;
`ifdef ECC_RANGE_CHECK_EN
                  r_err  <= 1'b0;
`endif
               end
            end
            S_CLASSIFY: begin
               if (w_trivial) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
                  if (w_rng) begin
                     r_x3   <= '0;
                     r_y3   <= '0;
                     r_inf3 <= 1'b0;
`ifdef ECC_RANGE_CHECK_EN
                     r_err  <= 1'b1;
`endif
                  end else if (r_inf1) begin
                     r_x3   <= r_inf2 ? '0 : r_x2;
                     r_y3   <= r_inf2 ? '0 : r_y2;
                     r_inf3 <= r_inf2;
                  end else if (r_inf2) begin
                     r_x3   <= r_x1;
                     r_y3   <= r_y1;
                     r_inf3 <= 1'b0;
                  end else begin
                     r_x3   <= '0;
                     r_y3   <= '0;
                     r_inf3 <= 1'b1;
                  end
               end else if (w_dbl) begin
                  r_dbl <= 1'b1;
                  r_den <= mod_add(r_y1, r_y1, r_p);
                  r_ma  <= r_x1;
                  r_mb  <= r_x1;
                  r_acc <= '0;
                  r_cnt <= '0;
               end else begin
                  r_dbl <= 1'b0;
                  r_num <= mod_sub(r_y2, r_y1, r_p);
                  r_den <= mod_sub(r_x2, r_x1, r_p);
               end
            end
            S_NUM: begin
               if (!r_dbl || w_mul_last) begin
                  if (r_dbl)
                     r_num <= w_num;
                  r_u   <= r_den;
                  r_v   <= r_p;
                  r_g1  <= N'(1);
                  r_g2  <= '0;
                  r_cnt <= '0;
               end else begin
                  r_acc <= w_acc_step;
                  r_ma  <= {r_ma[N-2:0], 1'b0};
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_INV: begin
               if (w_inv_done) begin
                  r_ma  <= r_num;
                  r_mb  <= w_inv;
                  r_acc <= '0;
                  r_cnt <= '0;
               end else begin
                  if (!r_u[0]) begin
                     r_u  <= r_u >> 1;
                     r_g1 <= mod_half(r_g1, r_p);
                  end else if (!r_v[0]) begin
                     r_v  <= r_v >> 1;
                     r_g2 <= mod_half(r_g2, r_p);
                  end else if (r_u >= r_v) begin
                     r_u  <= (r_u - r_v) >> 1;
                     r_g1 <= mod_half(w_g_diff12, r_p);
                  end else begin
                     r_v  <= (r_v - r_u) >> 1;
                     r_g2 <= mod_half(w_g_diff21, r_p);
                  end
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_LAM, S_X3, S_Y3: begin
               if (!w_mul_last) begin
                  r_acc <= w_acc_step;
                  r_ma  <= {r_ma[N-2:0], 1'b0};
                  r_cnt <= r_cnt + CW'(1);
               end else if (r_state == S_LAM) begin
                  r_lam <= w_acc_step;
                  r_ma  <= w_acc_step;
                  r_mb  <= w_acc_step;
                  r_acc <= '0;
                  r_cnt <= '0;
               end else if (r_state == S_X3) begin
                  r_x3t <= w_x3;
                  r_ma  <= r_lam;
                  r_mb  <= mod_sub(r_x1, w_x3, r_p);
                  r_acc <= '0;
                  r_cnt <= '0;
               end else begin
                  r_x3   <= r_x3t;
                  r_y3   <= mod_sub(w_acc_step, r_y1, r_p);
                  r_inf3 <= 1'b0;
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_x3   = r_x3;
   assign o_y3   = r_y3;
   assign o_inf3 = r_inf3;

endmodule
